// File: rtl/window_extractor.sv
// Sliding PATCH_SIZE x PATCH_SIZE window generator over a raster pixel stream.
// Latency: one cycle from pixel accept to the window containing it at the outputs.
// Backpressure: none downstream; enable=0 freezes all state, in_valid=0 only drops out_valid.
module window_extractor #(
    parameter int BIT_WIDTH    = 8,
    parameter int IMAGE_WIDTH  = 640,
    parameter int IMAGE_HEIGHT = 480,
    parameter int PATCH_SIZE   = 3
) (
    input  logic                                       clock,
    input  logic                                       n_rst,
    input  logic                                       enable,
    input  logic                                       in_valid,
    input  logic                                       in_sof,
    input  logic [BIT_WIDTH-1:0]                       in_data,
    output logic                                       out_valid,
    output logic [$clog2(IMAGE_WIDTH)-1:0]             out_hpos,
    output logic [$clog2(IMAGE_HEIGHT)-1:0]            out_vpos,
    output logic [BIT_WIDTH*PATCH_SIZE*PATCH_SIZE-1:0] out_data
);

    localparam int HW = $clog2(IMAGE_WIDTH);
    localparam int VW = $clog2(IMAGE_HEIGHT);
    localparam int NB = PATCH_SIZE - 1;

    localparam logic [HW-1:0] H_LAST = HW'(IMAGE_WIDTH - 1);
    localparam logic [VW-1:0] V_LAST = VW'(IMAGE_HEIGHT - 1);
    localparam logic [HW-1:0] H_EDGE = HW'(PATCH_SIZE - 1);
    localparam logic [VW-1:0] V_EDGE = VW'(PATCH_SIZE - 1);

    // Position counters: where the next accepted pixel lands.
    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;

    // Position of the pixel on the input this cycle (in_sof overrides the counters).
    logic [HW-1:0] pix_h;
    logic [VW-1:0] pix_v;
    logic [HW-1:0] next_h;
    logic [VW-1:0] next_v;
    logic          accept;
    logic          win_full;

    // Line buffers: buffer k holds the line k+1 above the current one.
    logic [BIT_WIDTH-1:0] lbuf    [NB][IMAGE_WIDTH];
    logic [BIT_WIDTH-1:0] lbuf_rd [NB];

    // Column entering the window on accept, index 0 = top (oldest line).
    logic [BIT_WIDTH-1:0] new_col [PATCH_SIZE];

    // Window registers, [row][column], row 0 top, column 0 left.
    logic [BIT_WIDTH-1:0] win [PATCH_SIZE][PATCH_SIZE];

    assign accept = enable & in_valid;

    // Resolve the incoming pixel's position and the counter values that follow it.
    always_comb begin
        pix_h  = in_sof ? '0 : hcnt;
        pix_v  = in_sof ? '0 : vcnt;
        next_h = pix_h + HW'(1);
        next_v = pix_v;
        if (pix_h == H_LAST) begin
            next_h = '0;
            next_v = (pix_v == V_LAST) ? '0 : pix_v + VW'(1);
        end
        win_full = (pix_h >= H_EDGE) && (pix_v >= V_EDGE);
    end

    // Asynchronous read of every line buffer at the incoming pixel's column.
    always_comb begin
        for (int k = 0; k < NB; k++) begin
            lbuf_rd[k] = lbuf[k][pix_h];
        end
    end

    // Assemble the new window column: older lines on top, the live pixel at the bottom.
    always_comb begin
        for (int r = 0; r < PATCH_SIZE - 1; r++) begin
            new_col[r] = lbuf_rd[PATCH_SIZE - 2 - r];
        end
        new_col[PATCH_SIZE-1] = in_data;
    end

    // Line-buffer cascade: read-before-write, each buffer's old value moves one line up.
    always_ff @(posedge clock) begin
        if (accept) begin
            lbuf[0][pix_h] <= in_data;
            for (int k = 1; k < NB; k++) begin
                lbuf[k][pix_h] <= lbuf_rd[k-1];
            end
        end
    end

    // Column/row counters advance on every accepted pixel.
    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (accept) begin
            hcnt <= next_h;
            vcnt <= next_v;
        end
    end

    // Window shift register: all rows shift left, new column enters on the right.
    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            for (int r = 0; r < PATCH_SIZE; r++) begin
                for (int c = 0; c < PATCH_SIZE; c++) begin
                    win[r][c] <= '0;
                end
            end
        end else if (accept) begin
            for (int r = 0; r < PATCH_SIZE; r++) begin
                for (int c = 0; c < PATCH_SIZE - 1; c++) begin
                    win[r][c] <= win[r][c+1];
                end
                win[r][PATCH_SIZE-1] <= new_col[r];
            end
        end
    end

    // Output qualifiers: position of the newest pixel and whether the window lies in-image.
    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            out_valid <= 1'b0;
            out_hpos  <= '0;
            out_vpos  <= '0;
        end else if (enable) begin
            if (in_valid) begin
                out_valid <= win_full;
                out_hpos  <= pix_h;
                out_vpos  <= pix_v;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

    // Flatten the window: element r*PATCH_SIZE+c occupies the c-th slot of row r.
    always_comb begin
        out_data = '0;
        for (int r = 0; r < PATCH_SIZE; r++) begin
            for (int c = 0; c < PATCH_SIZE; c++) begin
                out_data[BIT_WIDTH*(r*PATCH_SIZE+c) +: BIT_WIDTH] = win[r][c];
            end
        end
    end

endmodule

// File: tb/tb_window_extractor.sv
// Bench for window_extractor: a small 4x3 instance for directed scenarios and a
// 640-wide instance (short frame) for a long randomized run, both compared each
// cycle against a frame-array reference model.
module tb_window_extractor;

    localparam int P   = 3;
    localparam int SW  = 4;
    localparam int SH  = 3;
    localparam int BWD = 640;
    localparam int BHT = 32;

    localparam logic [71:0] WIN_A = 72'h22_21_20_12_11_10_02_01_00;
    localparam logic [71:0] WIN_B = 72'h23_22_21_13_12_11_03_02_01;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    // Small instance
    logic        s_rst_n, s_en, s_vld, s_sof;
    logic [7:0]  s_din;
    logic        s_ovld;
    logic [1:0]  s_oh;
    logic [1:0]  s_ov;
    logic [71:0] s_odat;

    // Wide instance
    logic        b_rst_n, b_en, b_vld, b_sof;
    logic [7:0]  b_din;
    logic        b_ovld;
    logic [9:0]  b_oh;
    logic [4:0]  b_ov;
    logic [71:0] b_odat;

    window_extractor #(.BIT_WIDTH(8), .IMAGE_WIDTH(SW), .IMAGE_HEIGHT(SH), .PATCH_SIZE(P)) u_small (
        .clock(clock), .n_rst(s_rst_n), .enable(s_en), .in_valid(s_vld), .in_sof(s_sof),
        .in_data(s_din), .out_valid(s_ovld), .out_hpos(s_oh), .out_vpos(s_ov), .out_data(s_odat)
    );

    window_extractor #(.BIT_WIDTH(8), .IMAGE_WIDTH(BWD), .IMAGE_HEIGHT(BHT), .PATCH_SIZE(P)) u_big (
        .clock(clock), .n_rst(b_rst_n), .enable(b_en), .in_valid(b_vld), .in_sof(b_sof),
        .in_data(b_din), .out_valid(b_ovld), .out_hpos(b_oh), .out_vpos(b_ov), .out_data(b_odat)
    );

    // Reference model: the frame as a pixel array plus expected output state.
    int          sel;
    int          m_w, m_h;
    int          m_hc, m_vc;
    logic [7:0]  img [BHT][BWD];
    logic        e_vld;
    int          e_h, e_v;
    logic [71:0] e_dat;
    bit          e_known;

    int          n_checks, n_pass, n_fail;
    int          pulses;
    logic [31:0] last_h, last_v;

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_hc    = 0;
        m_vc    = 0;
        e_vld   = 1'b0;
        e_h     = 0;
        e_v     = 0;
        e_dat   = '0;
        e_known = 1'b1;
    endtask

    task automatic model_accept(input bit sof, input logic [7:0] d);
        int ph, pv;
        ph = sof ? 0 : m_hc;
        pv = sof ? 0 : m_vc;
        img[pv][ph] = d;
        e_h   = ph;
        e_v   = pv;
        e_vld = (ph >= P - 1) && (pv >= P - 1);
        if (e_vld) begin
            for (int r = 0; r < P; r++)
                for (int c = 0; c < P; c++)
                    e_dat[8*(r*P+c) +: 8] = img[pv-P+1+r][ph-P+1+c];
            e_known = 1'b1;
        end else begin
            e_known = 1'b0;
        end
        if (ph == m_w - 1) begin
            m_hc = 0;
            m_vc = (pv == m_h - 1) ? 0 : pv + 1;
        end else begin
            m_hc = ph + 1;
            m_vc = pv;
        end
    endtask

    task automatic check_outputs(input string tag);
        logic        ov;
        logic [31:0] oh, ovp;
        logic [71:0] od;
        if (sel == 0) begin
            ov = s_ovld; oh = 32'(s_oh); ovp = 32'(s_ov); od = s_odat;
        end else begin
            ov = b_ovld; oh = 32'(b_oh); ovp = 32'(b_ov); od = b_odat;
        end
        chk({tag, " valid"}, 72'(ov), 72'(e_vld));
        chk({tag, " hpos"}, 72'(oh), 72'(e_h));
        chk({tag, " vpos"}, 72'(ovp), 72'(e_v));
        if (e_known) chk({tag, " data"}, od, e_dat);
        if (ov === 1'b1) begin
            pulses++;
            last_h = oh;
            last_v = ovp;
        end
    endtask

    task automatic step(input bit en, input bit vld, input bit sof, input logic [7:0] d, input string tag);
        if (sel == 0) begin
            s_en = en; s_vld = vld; s_sof = sof; s_din = d;
        end else begin
            b_en = en; b_vld = vld; b_sof = sof; b_din = d;
        end
        @(posedge clock);
        #1;
        if (en && vld) model_accept(sof, d);
        else if (en) e_vld = 1'b0;
        check_outputs(tag);
    endtask

    task automatic frame(input bit sof_first, input bit rnd, input int gap_pct, input int stall_n, input string tag);
        logic [7:0] d;
        int         g;
        for (int r = 0; r < m_h; r++) begin
            for (int c = 0; c < m_w; c++) begin
                d = rnd ? 8'($urandom) : 8'(16 * r + c);
                step(1'b1, 1'b1, sof_first && r == 0 && c == 0, d, tag);
                if (stall_n > 0 && r == P - 1 && c == P - 1)
                    for (int k = 0; k < stall_n; k++) step(1'b0, 1'b1, 1'b0, 8'hFF, {tag, " stall"});
                if (int'($urandom_range(0, 99)) < gap_pct) begin
                    g = $urandom_range(1, 2);
                    for (int k = 0; k < g; k++)
                        step(1'b1, 1'b0, 1'($urandom), 8'($urandom), {tag, " gap"});
                end
            end
        end
    endtask

    initial begin
        n_checks = 0; n_pass = 0; n_fail = 0; pulses = 0;
        last_h = '0; last_v = '0;
        s_rst_n = 1'b0; s_en = 1'b0; s_vld = 1'b0; s_sof = 1'b0; s_din = '0;
        b_rst_n = 1'b0; b_en = 1'b0; b_vld = 1'b0; b_sof = 1'b0; b_din = '0;
        m_w = SW; m_h = SH;
        model_reset();

        // Reset state of both instances
        #12;
        sel = 1; check_outputs("reset big");
        sel = 0; check_outputs("reset small");
        @(negedge clock);
        s_rst_n = 1'b1;

        // Scenario 1: full frame with continuous valid
        pulses = 0;
        for (int r = 0; r < SH; r++) begin
            for (int c = 0; c < SW; c++) begin
                step(1'b1, 1'b1, r == 0 && c == 0, 8'(16 * r + c), "s1");
                if (r == 2 && c == 2) chk("s1 first window", s_odat, WIN_A);
                if (r == 2 && c == 3) chk("s1 second window", s_odat, WIN_B);
            end
        end
        chk("s1 pulses", 72'(pulses), 72'd2);

        // Scenario 2: enable low for 5 cycles after pixel (2,2) with junk on the input
        pulses = 0;
        frame(1'b1, 1'b0, 0, 5, "s2");
        chk("s2 second window", s_odat, WIN_B);
        chk("s2 pulses", 72'(pulses), 72'd7);

        // Scenario 3: idle cycles after every pixel
        pulses = 0;
        frame(1'b1, 1'b0, 100, 0, "s3");
        chk("s3 held window", s_odat, WIN_B);
        chk("s3 pulses", 72'(pulses), 72'd2);

        // Scenario 4: two back-to-back frames, then an early restart at (1,1)
        pulses = 0;
        frame(1'b1, 1'b0, 0, 0, "s4a");
        frame(1'b1, 1'b0, 0, 0, "s4b");
        chk("s4 pulses two frames", 72'(pulses), 72'd4);
        pulses = 0;
        for (int i = 0; i < SW + 1; i++) step(1'b1, 1'b1, i == 0, 8'($urandom), "s4 partial");
        chk("s4 partial pulses", 72'(pulses), 72'd0);
        frame(1'b1, 1'b1, 20, 0, "s4 restart");
        chk("s4 restart pulses", 72'(pulses), 72'd2);

        // Scenario 5: asynchronous reset while out_valid is high
        for (int i = 0; i < 2 * SW + P; i++) step(1'b1, 1'b1, i == 0, 8'($urandom), "s5 pre");
        chk("s5 valid before reset", 72'(s_ovld), 72'd1);
        #2;
        s_rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("s5 async reset");
        @(negedge clock);
        s_rst_n = 1'b1;
        pulses = 0;
        frame(1'b0, 1'b1, 30, 0, "s5 post");
        chk("s5 pulses", 72'(pulses), 72'd2);
        s_vld = 1'b0;

        // Scenario 6: default-width instance over a shorter frame, random data and gaps
        sel = 1;
        m_w = BWD; m_h = BHT;
        model_reset();
        @(negedge clock);
        b_rst_n = 1'b1;
        pulses = 0;
        frame(1'b1, 1'b1, 10, 0, "big");
        chk("big pulses", 72'(pulses), 72'((BWD - P + 1) * (BHT - P + 1)));
        chk("big last hpos", 72'(last_h), 72'(BWD - 1));
        chk("big last vpos", 72'(last_v), 72'(BHT - 1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
